seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Receive side of the board's 7-segment display interface.
- Samples a multiplexed, active-low 4-digit segment bus plus active-low digit enables, and waits for each digit's pattern to settle.
- Converts each settled pattern back to a BCD value and assembles a 4-digit frame.
- Used to loop back and self-check display paths, and to read external 7-segment equipment.

Parameters:
- STABLE, 4: consecutive identical sampled cycles required before a digit is captured. Range 2..255.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- a  input  1  segment a, active-low (0 = lit)
- b  input  1  segment b, active-low
- c  input  1  segment c, active-low
- d  input  1  segment d, active-low
- e  input  1  segment e, active-low
- f  input  1  segment f, active-low
- g  input  1  segment g, active-low
- an  input  4  digit enables, active-low one-hot; an[0] = rightmost digit
- digits  output  16  captured frame; digits[4k+3:4k] = digit k
- frame_valid  output  1  one-cycle pulse when digits updates
- err  output  4  per-digit flag: last capture of digit k was an illegal pattern
- busy  output  1  high while at least one but not all digits are captured in the current frame

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high; it is sampled on the rising edge of clk.
- Reset values: digits = 16'hFFFF, frame_valid = 0, err = 4'b0000, busy = 0. The sample registers, stability counter, slot-captured mask and FSM are all cleared.
- Input sampling:
  - {a,b,c,d,e,f,g} and an are registered once (bus S) before use; there is no metastability synchroniser inside the block.
  - S is valid only if an has exactly one bit low. An invalid an (none low, or several low) forces the FSM to TRACK and clears the counter.
- FSM states:
  - TRACK:
    - If S equals the previous S, cnt increments, saturating at STABLE.
    - If S differs, cnt is cleared.
    - When cnt reaches STABLE-1 with the current S equal to the previous S, the digit is captured and the FSM goes to LOCKED.
  - LOCKED:
    - Holds while S is unchanged.
    - Any change in segments or an returns it to TRACK with cnt = 0.
    - No recapture happens while LOCKED.
- Capture timing: a pattern present on the pins for STABLE+1 rising edges is captured. The slot register updates on the edge after the STABLE-th identical sample.
- Decode table (pattern is abcdefg, active-low → value):
  - 0000001 → 0, 1001111 → 1, 0010010 → 2, 0000110 → 3, 1001100 → 4
  - 0100100 → 5, 0100000 → 6, 0001111 → 7, 0000000 → 8, 0000100 → 9
  - 1111111 (blank) → 4'hF, err bit cleared
  - any other pattern → 4'hE, err bit for that slot set
- Capture effect:
  - The value is written to an internal slot k, where k is the index of the low bit of an.
  - The captured mask bit k is set. Recapturing an already-captured slot overwrites its value and keeps the mask bit set.
- Frame completion:
  - On the cycle the mask becomes 4'b1111, the next edge copies all slots to digits, pulses frame_valid high for exactly 1 cycle, and clears the mask.
  - err updates in the same cycle as digits.
  - A capture in the same cycle as the mask clear counts toward the new frame.
- busy = (mask != 0) && (mask != 4'b1111).
- Reset mid-frame: the partial frame is discarded and digits returns to 4'hFFFF.
- Counter width is $clog2(STABLE+1). No wrap-around is permitted; the counter saturates.

Test Plan:
- Reset check: assert reset for 2 cycles with arbitrary inputs → digits = 16'hFFFF, err = 0, frame_valid = 0, busy = 0.
- Full frame: drive an=1110 seg=0000110 (3), an=1101 seg=1001111 (1), an=1011 seg=0100000 (6), an=0111 seg=0000100 (9), each held 10 cycles, STABLE=4 → single frame_valid pulse, digits = 16'h9613, err = 0; busy high between the first capture and frame_valid.
- Glitch rejection: hold an=1110 seg=0010010 for 3 cycles then 1 cycle of 0010011, then 0010010 for 10 cycles → only value 2 captured; slot 0 never sees an illegal value and err[0] = 0.
- Illegal and blank patterns: slot 1 receives 0110110, slot 2 receives 1111111, other slots receive 0 → digits = 16'h0FE0, err = 4'b0010.
- Invalid enables: an=1100 or 1111 held for 20 cycles with a valid pattern → no capture, mask unchanged, busy unchanged.
- Reset mid-frame: capture digits 0 and 1, assert reset for 1 cycle, then supply a full frame of 8s → exactly one frame_valid pulse, digits = 16'h8888.

Source files
------------

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - 7-segment bus receiver: debounces each multiplexed digit,
// decodes it back to BCD and assembles 4-digit frames.
module seg7_reader #(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [3:0]  err,
  output logic        busy
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE);
  localparam logic [CW-1:0] CNT_CAPT = CW'(STABLE - 1);

  localparam logic [0:0] ST_TRACK  = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // {abcdefg, an}
  logic [10:0]   s_d, s_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [0:0]    state_d, state_q;
  logic [15:0]   slot_d, slot_q;
  logic [3:0]    slot_err_d, slot_err_q;
  logic [3:0]    mask_d, mask_q;
  logic [15:0]   digits_d, digits_q;
  logic [3:0]    err_d, err_q;
  logic          fv_d, fv_q;

  logic          an_valid;
  logic          same;
  logic          capture;
  logic [1:0]    idx;
  logic [4:0]    dec;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  assign s_d = {a, b, c, d, e, f, g, an};

  always_comb begin
    an_valid = 1'b1;
    idx      = 2'd0;
    case (s_q[3:0])
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    slot_d     = slot_q;
    slot_err_d = slot_err_q;
    mask_d     = mask_q;
    digits_d   = digits_q;
    err_d      = err_q;
    fv_d       = 1'b0;
    capture    = 1'b0;
    same       = (s_d == s_q);
    dec        = decode(s_q[10:4]);

    if (!an_valid) begin
      state_d = ST_TRACK;
      cnt_d   = '0;
    end else begin
      if (same) begin
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
      if (state_q == ST_TRACK) begin
        if (same && cnt_q == CNT_CAPT) begin
          capture = 1'b1;
          state_d = ST_LOCKED;
        end
      end else if (!same) begin
        state_d = ST_TRACK;
      end
    end

    // Frame hand-off happens first so a capture on this edge starts the next frame.
    if (mask_q == 4'hF) begin
      digits_d = slot_q;
      err_d    = slot_err_q;
      fv_d     = 1'b1;
      mask_d   = 4'h0;
    end

    if (capture) begin
      slot_d[{idx, 2'b00} +: 4] = dec[3:0];
      slot_err_d[idx]           = dec[4];
      mask_d[idx]               = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q        <= '0;
      cnt_q      <= '0;
      state_q    <= ST_TRACK;
      slot_q     <= 16'hFFFF;
      slot_err_q <= 4'h0;
      mask_q     <= 4'h0;
      digits_q   <= 16'hFFFF;
      err_q      <= 4'h0;
      fv_q       <= 1'b0;
    end else begin
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      slot_q     <= slot_d;
      slot_err_q <= slot_err_d;
      mask_q     <= mask_d;
      digits_q   <= digits_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
    end
  end

  assign digits      = digits_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign busy        = (mask_q != 4'h0) && (mask_q != 4'hF);

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - randomized and directed bench for seg7_reader against a
// run-length reference model.
module tb_seg7_reader;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a, b, c, d, e, f, g;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;

  seg7_reader #(.STABLE(STABLE)) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .an(an), .digits(digits), .frame_valid(frame_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LEGAL [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [3:0] ONEHOT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference model: a digit is taken once its pin pattern has been seen on
  // STABLE+1 consecutive edges; a frame is published on the edge after all four are in.
  int          run;
  logic [10:0] last;
  logic [3:0]  slot_m [4];
  logic [3:0]  serr_m;
  logic [3:0]  mask_m;
  logic [15:0] exp_digits;
  logic [3:0]  exp_err;
  logic        exp_fv;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (p == LEGAL[i]) return {1'b0, 4'(i)};
    if (p == 7'h7F) return 5'h0F;
    return 5'h1E;
  endfunction

  task automatic model_edge();
    logic [10:0] cur;
    logic [4:0]  v;
    int          k;
    if (reset) begin
      run = 0; mask_m = 0; exp_digits = 16'hFFFF; exp_err = 0; exp_fv = 0;
    end else begin
      exp_fv = 0;
      if (mask_m == 4'hF) begin
        exp_digits = {slot_m[3], slot_m[2], slot_m[1], slot_m[0]};
        exp_err    = serr_m;
        exp_fv     = 1;
        mask_m     = 0;
      end
      cur = {a, b, c, d, e, f, g, an};
      if (run == 0 || cur != last) run = 1;
      else if (run < 1000) run++;
      last = cur;
      if (run == STABLE + 1 && $countones(~an) == 1) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) k = i;
        v = ref_decode(cur[10:4]);
        slot_m[k] = v[3:0];
        serr_m[k] = v[4];
        mask_m[k] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic [3:0] an_v, input logic rst);
    {a, b, c, d, e, f, g} = seg;
    an    = an_v;
    reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    check("digits", digits, exp_digits);
    check("frame_valid", {15'b0, frame_valid}, {15'b0, exp_fv});
    check("err", {12'b0, err}, {12'b0, exp_err});
    check("busy", {15'b0, busy}, {15'b0, (mask_m != 0 && mask_m != 4'hF)});
    if (frame_valid) fv_seen++;
  endtask

  task automatic hold(input logic [6:0] seg, input logic [3:0] an_v, input int n);
    for (int i = 0; i < n; i++) step(seg, an_v, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(7'($urandom), 4'($urandom), 1'b1);
  endtask

  initial begin
    int fv0;
    logic [3:0] busy_before;
    run = 0; last = '0; mask_m = 0; serr_m = 0; exp_digits = 16'hFFFF; exp_err = 0; exp_fv = 0;
    for (int i = 0; i < 4; i++) slot_m[i] = 4'hF;

    // Reset with arbitrary inputs
    do_reset(2);
    check("rst_digits", digits, 16'hFFFF);
    check("rst_err", {12'b0, err}, 16'h0);
    check("rst_fv", {15'b0, frame_valid}, 16'h0);
    check("rst_busy", {15'b0, busy}, 16'h0);

    // Full frame 9613
    fv0 = fv_seen;
    hold(7'b0000110, 4'b1110, 10);
    hold(7'b1001111, 4'b1101, 10);
    hold(7'b0100000, 4'b1011, 10);
    hold(7'b0000100, 4'b0111, 10);
    check("frame_9613", digits, 16'h9613);
    check("frame_9613_err", {12'b0, err}, 16'h0);
    check("frame_9613_pulses", 16'(fv_seen - fv0), 16'd1);

    // Glitch rejection on slot 0
    do_reset(1);
    hold(7'b0010010, 4'b1110, 3);
    hold(7'b0010011, 4'b1110, 1);
    hold(7'b0010010, 4'b1110, 10);
    hold(7'b0000001, 4'b1101, 10);
    hold(7'b0000001, 4'b1011, 10);
    hold(7'b0000001, 4'b0111, 10);
    check("glitch_digits", digits, 16'h0002);
    check("glitch_err", {12'b0, err}, 16'h0);

    // Illegal and blank patterns
    do_reset(1);
    hold(7'b0000001, 4'b1110, 10);
    hold(7'b0110110, 4'b1101, 10);
    hold(7'b1111111, 4'b1011, 10);
    hold(7'b0000001, 4'b0111, 10);
    check("illegal_digits", digits, 16'h0FE0);
    check("illegal_err", {12'b0, err}, 16'h0002);

    // Invalid enables leave a partial frame untouched
    do_reset(1);
    hold(7'b1001100, 4'b1110, 10);
    busy_before = {3'b0, busy};
    hold(7'b1001100, 4'b1100, 20);
    hold(7'b1001100, 4'b1111, 20);
    check("invalid_an_busy", {15'b0, busy}, {12'b0, busy_before});
    check("invalid_an_busy_set", {15'b0, busy}, 16'd1);
    check("invalid_an_digits", digits, 16'hFFFF);

    // Reset mid-frame, then a frame of 8s
    do_reset(1);
    hold(7'b1001111, 4'b1110, 10);
    hold(7'b0010010, 4'b1101, 10);
    do_reset(1);
    check("midrst_digits", digits, 16'hFFFF);
    fv0 = fv_seen;
    hold(7'b0000000, 4'b1110, 10);
    hold(7'b0000000, 4'b1101, 10);
    hold(7'b0000000, 4'b1011, 10);
    hold(7'b0000000, 4'b0111, 10);
    check("midrst_8888", digits, 16'h8888);
    check("midrst_pulses", 16'(fv_seen - fv0), 16'd1);

    // Randomized traffic: legal, blank, illegal, invalid enables, short glitches, resets
    for (int n = 0; n < 400; n++) begin
      logic [6:0] seg;
      logic [3:0] an_v;
      int sel;
      sel = $urandom_range(0, 13);
      if (sel < 10) seg = LEGAL[sel];
      else if (sel == 10) seg = 7'h7F;
      else seg = 7'($urandom);
      if ($urandom_range(0, 5) == 0) an_v = 4'($urandom);
      else an_v = ONEHOT[$urandom_range(0, 3)];
      if ($urandom_range(0, 60) == 0) do_reset(1);
      else hold(seg, an_v, $urandom_range(1, 9));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
